// File: rtl/fp_cmp_stage_pkg.sv
// -----------------------------------------------------------------------------
// fp_cmp_stage_pkg
//  Shared definitions for the RV32F compare/select execute stage:
//  operation encodings, canonical quiet NaN, FCLASS one-hot bit indices and a
//  light operand classifier used by the first pipeline stage.
//  Optional feature macro: FP_CMP_FCLASS_EN (enables FCLASS.S on op 5).
// -----------------------------------------------------------------------------
package fp_cmp_stage_pkg;

    typedef enum logic [2:0] {
        FP_OP_FMIN   = 3'd0,
        FP_OP_FMAX   = 3'd1,
        FP_OP_FEQ    = 3'd2,
        FP_OP_FLT    = 3'd3,
        FP_OP_FLE    = 3'd4,
        FP_OP_FCLASS = 3'd5
    } fp_op_e;

    // Canonical NaN returned when both FMIN/FMAX operands are NaN.
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // FCLASS.S result bit positions.
    localparam int FP_CLS_NEG_INF  = 0;
    localparam int FP_CLS_NEG_NORM = 1;
    localparam int FP_CLS_NEG_SUB  = 2;
    localparam int FP_CLS_NEG_ZERO = 3;
    localparam int FP_CLS_POS_ZERO = 4;
    localparam int FP_CLS_POS_SUB  = 5;
    localparam int FP_CLS_POS_NORM = 6;
    localparam int FP_CLS_POS_INF  = 7;
    localparam int FP_CLS_SNAN     = 8;
    localparam int FP_CLS_QNAN     = 9;

    // Per-operand flags precomputed in stage 1 so stage 2 only does the
    // magnitude compare and result muxing.
    typedef struct packed {
        logic sign;
        logic nan;
        logic snan;
        logic zero;
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t c;
        logic      exp_ones;
        logic      frac_nz;
        exp_ones = (x[30:23] == 8'hFF);
        frac_nz  = (x[22:0] != 23'd0);
        c.sign   = x[31];
        c.nan    = exp_ones && frac_nz;
        // Signalling NaN: quiet bit (frac MSB) clear.
        c.snan   = exp_ones && frac_nz && !x[22];
        c.zero   = (x[30:0] == 31'd0);
        return c;
    endfunction

endpackage

// File: rtl/fp_cmp_stage_if.sv
// -----------------------------------------------------------------------------
// fp_cmp_stage_if
//  Issue-side and writeback-side handshake bundle for fp_cmp_stage.
//  master : the issue/writeback environment (drives operands, out_ready,
//           flush and the sticky-flag clear)
//  slave  : the compare stage itself
//  Signals: in_valid/in_ready/in_op/in_a/in_b/in_tag, out_valid/out_ready/
//           out_data/out_tag/out_nv, flush, fflags_nv, fflags_clr.
// -----------------------------------------------------------------------------
interface fp_cmp_stage_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_nv;
    logic             fflags_nv;
    logic             fflags_clr;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready, fflags_clr,
        input  in_ready, out_valid, out_data, out_tag, out_nv, fflags_nv
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready, fflags_clr,
        output in_ready, out_valid, out_data, out_tag, out_nv, fflags_nv
    );
endinterface

// File: rtl/fp_cmp_stage_core.sv
// -----------------------------------------------------------------------------
// fp_cmp_core
//  Combinational compare/select datapath between stage 1 and stage 2.
//  Inputs : op (3b), a/b operands (32b), cls_a/cls_b precomputed flags.
//  Outputs: result (FP value, 0/1 integer, or FCLASS mask), nv (invalid flag).
//  Optional feature macro: FP_CMP_FCLASS_EN (op 5 = FCLASS.S; otherwise op 5
//  is treated as illegal and no classify logic exists).
// -----------------------------------------------------------------------------
module fp_cmp_core
    import fp_cmp_stage_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  fp_class_t   cls_a,
    input  fp_class_t   cls_b,
    output logic [31:0] result,
    output logic        nv
);

    logic any_nan;
    logic any_snan;
    logic both_zero;
    logic lt_ord;
    logic eq_ord;
    logic min_pick_a;
    logic max_pick_a;
`ifdef FP_CMP_FCLASS_EN
    logic [9:0] cls_onehot;
`endif

    always_comb begin
        any_nan   = cls_a.nan  || cls_b.nan;
        any_snan  = cls_a.snan || cls_b.snan;
        both_zero = cls_a.zero && cls_b.zero;

        // Ordered less-than on sign-magnitude encodings, NaNs excluded later.
        // Zeros of either sign are equal; for negatives the larger magnitude
        // is the smaller number.
        if (both_zero)
            lt_ord = 1'b0;
        else if (cls_a.sign != cls_b.sign)
            lt_ord = cls_a.sign;
        else if (!cls_a.sign)
            lt_ord = (a[30:0] < b[30:0]);
        else
            lt_ord = (b[30:0] < a[30:0]);

        eq_ord = both_zero || (a == b);

        // Signed zeros: min prefers -0, max prefers +0.
        min_pick_a = lt_ord || (both_zero ? cls_a.sign : eq_ord);
        max_pick_a = !lt_ord && !(both_zero && cls_a.sign);

`ifdef FP_CMP_FCLASS_EN
        cls_onehot = '0;
        if (cls_a.nan) begin
            if (cls_a.snan) cls_onehot[FP_CLS_SNAN] = 1'b1;
            else            cls_onehot[FP_CLS_QNAN] = 1'b1;
        end else if (a[30:23] == 8'hFF) begin
            if (cls_a.sign) cls_onehot[FP_CLS_NEG_INF] = 1'b1;
            else            cls_onehot[FP_CLS_POS_INF] = 1'b1;
        end else if (cls_a.zero) begin
            if (cls_a.sign) cls_onehot[FP_CLS_NEG_ZERO] = 1'b1;
            else            cls_onehot[FP_CLS_POS_ZERO] = 1'b1;
        end else if (a[30:23] == 8'h00) begin
            if (cls_a.sign) cls_onehot[FP_CLS_NEG_SUB] = 1'b1;
            else            cls_onehot[FP_CLS_POS_SUB] = 1'b1;
        end else begin
            if (cls_a.sign) cls_onehot[FP_CLS_NEG_NORM] = 1'b1;
            else            cls_onehot[FP_CLS_POS_NORM] = 1'b1;
        end
`endif

        result = 32'd0;
        nv     = 1'b0;
        case (op)
            FP_OP_FMIN, FP_OP_FMAX: begin
                nv = any_snan;
                if (cls_a.nan && cls_b.nan)
                    result = FP_QNAN;
                else if (cls_a.nan)
                    result = b;
                else if (cls_b.nan)
                    result = a;
                else if (op == FP_OP_FMIN)
                    result = min_pick_a ? a : b;
                else
                    result = max_pick_a ? a : b;
            end
            FP_OP_FEQ: begin
                nv     = any_snan;
                result = {31'd0, !any_nan && eq_ord};
            end
            // Signalling compares: any NaN raises NV.
            FP_OP_FLT: begin
                nv     = any_nan;
                result = {31'd0, !any_nan && lt_ord};
            end
            FP_OP_FLE: begin
                nv     = any_nan;
                result = {31'd0, !any_nan && (lt_ord || eq_ord)};
            end
`ifdef FP_CMP_FCLASS_EN
            FP_OP_FCLASS: begin
                result = {22'd0, cls_onehot};
            end
`endif
            default: begin
                result = 32'd0;
                nv     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fp_cmp_stage.sv
// -----------------------------------------------------------------------------
// fp_cmp_stage
//  Two-stage pipelined RV32F compare/select execute stage (FMIN.S, FMAX.S,
//  FEQ.S, FLT.S, FLE.S, optional FCLASS.S).
//  Ports: clk, rst (asynchronous, active high), bus (fp_cmp_stage_if.slave):
//   in_*  operand bundle with valid/ready, out_* result bundle with
//   valid/ready plus per-result NV, flush kills both stages, fflags_nv is the
//   sticky NV accumulator cleared by fflags_clr.
//  Stage 1 registers the operands with their classification, stage 2
//  registers the core result. Latency 2, throughput 1, no skid buffer:
//  in_ready depends combinationally on out_ready.
//  Optional feature macro: FP_CMP_FCLASS_EN.
// -----------------------------------------------------------------------------
module fp_cmp_stage
    import fp_cmp_stage_pkg::*;
#(
    parameter int WIDTH = 32,   // only 32 is supported
    parameter int TAG_W = 5
) (
    input logic          clk,
    input logic          rst,
    fp_cmp_stage_if.slave bus
);

    // Stage 1
    logic             s1_valid_reg;
    logic [2:0]       s1_op_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    fp_class_t        s1_cls_a_reg;
    fp_class_t        s1_cls_b_reg;

    // Stage 2 (drives the output bundle directly)
    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_data_reg;
    logic [TAG_W-1:0] s2_tag_reg;
    logic             s2_nv_reg;

    logic             fflags_nv_reg;

    logic             s2_ready;
    logic             s1_advance;
    logic             in_ready;
    logic             in_fire;
    logic [31:0]      core_result;
    logic             core_nv;

    // Stage 2 can take a new bundle when empty or being drained this cycle.
    assign s2_ready   = !s2_valid_reg || bus.out_ready;
    assign s1_advance = s1_valid_reg && s2_ready;
    assign in_ready   = !s1_valid_reg || s1_advance;
    assign in_fire    = bus.in_valid && in_ready;

    fp_cmp_core u_core (
        .op     (s1_op_reg),
        .a      (s1_a_reg),
        .b      (s1_b_reg),
        .cls_a  (s1_cls_a_reg),
        .cls_b  (s1_cls_b_reg),
        .result (core_result),
        .nv     (core_nv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_op_reg     <= 3'd0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_tag_reg    <= '0;
            s1_cls_a_reg  <= '0;
            s1_cls_b_reg  <= '0;
            s2_valid_reg  <= 1'b0;
            s2_data_reg   <= '0;
            s2_tag_reg    <= '0;
            s2_nv_reg     <= 1'b0;
            fflags_nv_reg <= 1'b0;
        end else begin
            // Valid bits: flush wins over any transfer in the same cycle,
            // which also drops the bundle presented during the flush.
            if (bus.flush)
                s1_valid_reg <= 1'b0;
            else if (in_ready)
                s1_valid_reg <= bus.in_valid;

            if (bus.flush)
                s2_valid_reg <= 1'b0;
            else if (s2_ready)
                s2_valid_reg <= s1_valid_reg;

            // Payload registers only move on a transfer, so the output bundle
            // is stable while stalled.
            if (in_fire) begin
                s1_op_reg    <= bus.in_op;
                s1_a_reg     <= bus.in_a;
                s1_b_reg     <= bus.in_b;
                s1_tag_reg   <= bus.in_tag;
                s1_cls_a_reg <= fp_classify(bus.in_a);
                s1_cls_b_reg <= fp_classify(bus.in_b);
            end

            if (s1_advance) begin
                s2_data_reg <= core_result;
                s2_tag_reg  <= s1_tag_reg;
                s2_nv_reg   <= core_nv;
            end

            // A new NV event beats a coincident CSR clear.
            if (s2_valid_reg && bus.out_ready && s2_nv_reg)
                fflags_nv_reg <= 1'b1;
            else if (bus.fflags_clr)
                fflags_nv_reg <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_reg;
    assign bus.out_data  = s2_data_reg;
    assign bus.out_tag   = s2_tag_reg;
    assign bus.out_nv    = s2_nv_reg;
    assign bus.fflags_nv = fflags_nv_reg;

endmodule
